// File: rtl/flt_mul_pipe.sv
// flt_mul_pipe: three-stage unsigned floating-point multiplier ({exp, mantissa},
// hidden leading one, biased exponent) with valid/ready flow control,
// selectable rounding (nearest-even or half-up) and saturating
// overflow / flushing underflow.
module flt_mul_pipe #(
    parameter int unsigned EXP_L = 8,
    parameter int unsigned MNT_L = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_L+MNT_L-1:0] in1,
    input  logic [EXP_L+MNT_L-1:0] in2,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_L+MNT_L-1:0] out,
    output logic [2:0]             flags
);

    localparam int unsigned W    = EXP_L + MNT_L;
    localparam int unsigned PW   = 2 * MNT_L + 2;
    localparam int unsigned SW   = EXP_L + 2;
    localparam int unsigned SIGW = MNT_L + 1;
    localparam int unsigned BIAS = (1 << (EXP_L - 1)) - 1;

    // Global stall: every stage moves only when the output slot can drain.
    logic advance;

    // Stage 1 state: significand product, raw exponent sum, zero and mode.
    logic          s1_valid;
    logic [PW-1:0] s1_prod;
    logic [SW-1:0] s1_esum;
    logic          s1_zero;
    logic          s1_mode;

    // Stage 2 state: normalised mantissa, biased exponent and G/R/S bits.
    logic             s2_valid;
    logic [MNT_L-1:0] s2_mant;
    logic [SW-1:0]    s2_exp;
    logic             s2_guard;
    logic             s2_round;
    logic             s2_sticky;
    logic             s2_zero;
    logic             s2_mode;

    // Stage 1 combinational inputs
    logic [SIGW-1:0] a_sig;
    logic [SIGW-1:0] b_sig;
    logic [PW-1:0]   prod_c;
    logic [SW-1:0]   esum_c;
    logic            zero_c;

    // Stage 2 combinational inputs
    logic             norm_c;
    logic [SW-1:0]    exp_n_c;
    logic [MNT_L-1:0] mant_n_c;
    logic             guard_c;
    logic             round_c;
    logic             sticky_c;

    // Stage 3 combinational inputs
    logic             inc_c;
    logic [MNT_L:0]   mant_sum_c;
    logic [SW-1:0]    exp_r_c;
    logic [W-1:0]     res_c;
    logic [2:0]       res_flags_c;

    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    // Operand decode and full-width significand product / exponent sum
    always_comb begin
        a_sig  = {1'b1, in1[MNT_L-1:0]};
        b_sig  = {1'b1, in2[MNT_L-1:0]};
        prod_c = PW'(a_sig) * PW'(b_sig);
        esum_c = SW'(in1[W-1:MNT_L]) + SW'(in2[W-1:MNT_L]);
        zero_c = (in1 == '0) || (in2 == '0);
    end

    // Normalise: a product of 2.0 or more shifts right by one and bumps the exponent
    always_comb begin
        norm_c   = s1_prod[PW-1];
        exp_n_c  = s1_esum + SW'(norm_c) - SW'(BIAS);
        mant_n_c = '0;
        guard_c  = 1'b0;
        round_c  = 1'b0;
        sticky_c = 1'b0;
        if (norm_c) begin
            mant_n_c = s1_prod[2*MNT_L -: MNT_L];
            guard_c  = s1_prod[MNT_L];
            round_c  = s1_prod[MNT_L-1];
            sticky_c = |s1_prod[MNT_L-2:0];
        end else begin
            mant_n_c = s1_prod[2*MNT_L-1 -: MNT_L];
            guard_c  = s1_prod[MNT_L-1];
            round_c  = s1_prod[MNT_L-2];
            sticky_c = |s1_prod[MNT_L-3:0];
        end
    end

    // Round, then classify as zero, underflow, overflow or normal
    always_comb begin
        inc_c       = s2_mode ? s2_guard
                              : (s2_guard && (s2_round || s2_sticky || s2_mant[0]));
        mant_sum_c  = (MNT_L + 1)'(s2_mant) + (MNT_L + 1)'(inc_c);
        exp_r_c     = s2_exp + SW'(mant_sum_c[MNT_L]);
        res_c       = {exp_r_c[EXP_L-1:0], mant_sum_c[MNT_L-1:0]};
        res_flags_c = 3'b000;
        if (s2_zero) begin
            res_c       = '0;
            res_flags_c = 3'b001;
        end else if (s2_exp[SW-1] || (s2_exp == '0)) begin
            res_c       = '0;
            res_flags_c = 3'b011;
        end else if (exp_r_c[SW-1:EXP_L] != '0) begin
            res_c       = '1;
            res_flags_c = 3'b100;
        end
    end

    // Stage-valid chain and output register; reset discards every beat in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out   <= res_c;
                flags <= res_flags_c;
            end
        end
    end

    // Datapath registers for stages 1 and 2; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_prod   <= prod_c;
            s1_esum   <= esum_c;
            s1_zero   <= zero_c;
            s1_mode   <= rnd_mode;
            s2_mant   <= mant_n_c;
            s2_exp    <= exp_n_c;
            s2_guard  <= guard_c;
            s2_round  <= round_c;
            s2_sticky <= sticky_c;
            s2_zero   <= s1_zero;
            s2_mode   <= s1_mode;
        end
    end

endmodule
